// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the D-PHY data-lane transmit controller.
package mipi_tx_pkg;

    typedef enum logic [2:0] {
        STOP    = 3'd0,
        RQST    = 3'd1,
        BRIDGE  = 3'd2,
        HSZERO  = 3'd3,
        SYNC    = 3'd4,
        PAYLOAD = 3'd5,
        TRAIL   = 3'd6,
        EXIT    = 3'd7
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP pad pair encodings, ordered {DP, DN}.
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mipi_tx_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational from the count.
module mipi_tx_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mipi_tx_lane_ctrl.sv
// D-PHY data-lane transmit controller: sequences LP request, HS prepare/zero,
// sync, payload, trail and exit, driving the serializer word and LP pads.
module mipi_tx_lane_ctrl
    import mipi_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 10,
    parameter int T_HS_TRAIL   = 6,
    parameter int T_HS_EXIT    = 5
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             PLL_LOCK,
    input  logic             TX_REQ,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    input  logic             TX_LAST,
    output logic             TX_READY,
    output logic [WIDTH-1:0] HS_TX_DATA,
    output logic             HS_EN,
    output logic             LP_EN,
    output logic             LP_TX_DP,
    output logic             LP_TX_DN,
    output logic             TX_ACTIVE,
    output logic             TX_ERR
);

    localparam int T_MAX = max_int(max_int(max_int(T_LPX, T_HS_PREPARE),
                                           max_int(T_HS_ZERO, T_HS_TRAIL)), T_HS_EXIT);
    localparam int TW    = $clog2(T_MAX + 1);

    if (WIDTH != 8) begin : g_bad_width
        $error("mipi_tx_lane_ctrl: WIDTH must be 8");
    end
    if (T_LPX < 1 || T_HS_PREPARE < 1 || T_HS_ZERO < 1 || T_HS_TRAIL < 1 || T_HS_EXIT < 1) begin : g_bad_timing
        $error("mipi_tx_lane_ctrl: timing parameters must be at least 1");
    end

    tx_state_t        state;
    tx_state_t        next_state;
    tx_state_t        pad_state;
    logic             tx_err_d;
    logic             hs_take;
    logic             tmr_load;
    logic [TW-1:0]    tmr_load_val;
    logic             tmr_zero;
    logic [WIDTH-1:0] last_byte;

    // Payload handshake: a byte is taken on any cycle with TX_VALID & TX_READY.
    // TX_READY depends only on the state register, never on TX_VALID.
    assign TX_READY = (state == SYNC) || (state == PAYLOAD);
    assign hs_take  = TX_VALID && TX_READY;

    always_comb begin
        next_state = state;
        tx_err_d   = 1'b0;
        case (state)
            STOP: begin
                if (TX_REQ && PLL_LOCK) next_state = RQST;
            end
            RQST: begin
                if (!PLL_LOCK)     next_state = EXIT;
                else if (tmr_zero) next_state = BRIDGE;
            end
            BRIDGE: begin
                if (!PLL_LOCK)     next_state = EXIT;
                else if (tmr_zero) next_state = HSZERO;
            end
            HSZERO: begin
                if (!PLL_LOCK) begin
                    next_state = EXIT;
                    tx_err_d   = 1'b1;
                end else if (tmr_zero) begin
                    next_state = SYNC;
                end
            end
            SYNC: begin
                if (!PLL_LOCK) begin
                    next_state = EXIT;
                    tx_err_d   = 1'b1;
                end else if (hs_take && TX_LAST) begin
                    next_state = TRAIL;
                end else begin
                    next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // PLL loss wins over a simultaneous handshake; that byte is dropped.
                if (!PLL_LOCK) begin
                    next_state = EXIT;
                    tx_err_d   = 1'b1;
                end else if (!TX_VALID) begin
                    next_state = TRAIL;
                    tx_err_d   = 1'b1;
                end else if (TX_LAST) begin
                    next_state = TRAIL;
                end
            end
            TRAIL: begin
                if (!PLL_LOCK) begin
                    next_state = EXIT;
                    tx_err_d   = 1'b1;
                end else if (tmr_zero) begin
                    next_state = EXIT;
                end
            end
            EXIT: begin
                if (tmr_zero) next_state = STOP;
            end
            default: next_state = STOP;
        endcase
    end

    assign tmr_load = (next_state != state);

    always_comb begin
        tmr_load_val = '0;
        case (next_state)
            RQST:    tmr_load_val = TW'(T_LPX - 1);
            BRIDGE:  tmr_load_val = TW'(T_HS_PREPARE - 1);
            HSZERO:  tmr_load_val = TW'(T_HS_ZERO - 1);
            TRAIL:   tmr_load_val = TW'(T_HS_TRAIL - 1);
            EXIT:    tmr_load_val = TW'(T_HS_EXIT - 1);
            default: tmr_load_val = '0;
        endcase
    end

    mipi_tx_timer #(.W(TW)) u_timer (
        .clk      (CLK_IN),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    // The HS word path has one cycle of latency from handshake to pad, so the
    // final trail word is still on the lane in the first EXIT cycle unless aborted.
    assign pad_state = (state == TRAIL && PLL_LOCK) ? TRAIL : next_state;

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state      <= STOP;
            LP_TX_DP   <= 1'b1;
            LP_TX_DN   <= 1'b1;
            LP_EN      <= 1'b1;
            HS_EN      <= 1'b0;
            HS_TX_DATA <= '0;
            TX_ACTIVE  <= 1'b0;
            TX_ERR     <= 1'b0;
            last_byte  <= SYNC_BYTE;
        end else begin
            state     <= next_state;
            TX_ERR    <= tx_err_d;
            TX_ACTIVE <= (state != STOP) || (next_state != STOP);

            if (next_state == SYNC) begin
                last_byte <= SYNC_BYTE;
            end else if (hs_take) begin
                last_byte <= TX_DATA;
            end

            case (pad_state)
                RQST, BRIDGE: begin
                    LP_EN                <= 1'b1;
                    HS_EN                <= 1'b0;
                    {LP_TX_DP, LP_TX_DN} <= (pad_state == RQST) ? LP01 : LP00;
                    HS_TX_DATA           <= '0;
                end
                HSZERO, SYNC: begin
                    LP_EN                <= 1'b0;
                    HS_EN                <= 1'b1;
                    {LP_TX_DP, LP_TX_DN} <= LP00;
                    HS_TX_DATA           <= (pad_state == SYNC) ? SYNC_BYTE : '0;
                end
                PAYLOAD, TRAIL: begin
                    LP_EN                <= 1'b0;
                    HS_EN                <= 1'b1;
                    {LP_TX_DP, LP_TX_DN} <= LP00;
                    // With no byte to send, fill with the inverse of the last sent MSB.
                    HS_TX_DATA           <= hs_take ? TX_DATA : {WIDTH{~last_byte[WIDTH-1]}};
                end
                default: begin
                    LP_EN                <= 1'b1;
                    HS_EN                <= 1'b0;
                    {LP_TX_DP, LP_TX_DN} <= LP11;
                    HS_TX_DATA           <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_tx_lane_ctrl.sv
// Directed bench for mipi_tx_lane_ctrl; cycle k is the cycle after the k-th edge
// counted from the edge that first samples TX_REQ=1 in STOP (edge 0).
module tb_mipi_tx_lane_ctrl;

    logic       CLK_IN = 1'b0;
    logic       RST;
    logic       PLL_LOCK;
    logic       TX_REQ;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_LAST;
    logic       TX_READY;
    logic [7:0] HS_TX_DATA;
    logic       HS_EN;
    logic       LP_EN;
    logic       LP_TX_DP;
    logic       LP_TX_DN;
    logic       TX_ACTIVE;
    logic       TX_ERR;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK_IN = ~CLK_IN;

    mipi_tx_lane_ctrl dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .PLL_LOCK   (PLL_LOCK),
        .TX_REQ     (TX_REQ),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_LAST    (TX_LAST),
        .TX_READY   (TX_READY),
        .HS_TX_DATA (HS_TX_DATA),
        .HS_EN      (HS_EN),
        .LP_EN      (LP_EN),
        .LP_TX_DP   (LP_TX_DP),
        .LP_TX_DN   (LP_TX_DN),
        .TX_ACTIVE  (TX_ACTIVE),
        .TX_ERR     (TX_ERR)
    );

    task automatic step();
        @(posedge CLK_IN);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic [7:0] d, input logic hs, input logic dp,
                           input logic dn, input logic rdy, input logic act, input logic err);
        chk({t, ".data"},   HS_TX_DATA,          d);
        chk({t, ".hs_en"},  {7'd0, HS_EN},       {7'd0, hs});
        chk({t, ".lp_en"},  {7'd0, LP_EN},       {7'd0, ~hs});
        chk({t, ".dp"},     {7'd0, LP_TX_DP},    {7'd0, dp});
        chk({t, ".dn"},     {7'd0, LP_TX_DN},    {7'd0, dn});
        chk({t, ".ready"},  {7'd0, TX_READY},    {7'd0, rdy});
        chk({t, ".active"}, {7'd0, TX_ACTIVE},   {7'd0, act});
        chk({t, ".err"},    {7'd0, TX_ERR},      {7'd0, err});
    endtask

    task automatic kick();
        cyc    = 0;
        TX_REQ = 1'b1;
    endtask

    initial begin
        logic [7:0] ed;

        // Clock/reset
        RST      = 1'b1;
        PLL_LOCK = 1'b1;
        TX_REQ   = 1'b0;
        TX_DATA  = 8'h00;
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
        repeat (3) step();
        chk_all("reset", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        step();
        chk_all("idle", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Nominal burst: 0x11, 0x22, 0xA5 (last)
        TX_VALID = 1'b1;
        TX_DATA  = 8'h11;
        kick();
        for (int k = 1; k <= 34; k++) begin
            step();
            TX_REQ  = 1'b0;
            TX_DATA = (cyc == 19) ? 8'h22 : (cyc == 20) ? 8'hA5 : 8'h11;
            TX_LAST = (cyc == 20);
            ed = (cyc == 18) ? 8'hB8 : (cyc == 19) ? 8'h11 : (cyc == 20) ? 8'h22 :
                 (cyc == 21) ? 8'hA5 : 8'h00;
            chk_all("nominal", ed, (cyc >= 8 && cyc <= 27), (cyc >= 28), (cyc <= 4 || cyc >= 28),
                    (cyc >= 18 && cyc <= 20), (cyc <= 32), 1'b0);
        end
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
        step();

        // Trail polarity: single byte 0x7F -> trail 0xFF
        TX_VALID = 1'b1;
        TX_DATA  = 8'h7F;
        TX_LAST  = 1'b1;
        kick();
        for (int k = 1; k <= 31; k++) begin
            step();
            TX_REQ = 1'b0;
            ed = (cyc == 18) ? 8'hB8 : (cyc == 19) ? 8'h7F :
                 (cyc >= 20 && cyc <= 25) ? 8'hFF : 8'h00;
            chk_all("trail", ed, (cyc >= 8 && cyc <= 25), (cyc >= 26), (cyc <= 4 || cyc >= 26),
                    (cyc == 18), (cyc <= 30), 1'b0);
        end
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
        step();

        // Underflow: VALID drops after 0x11, 0x80
        TX_VALID = 1'b1;
        TX_DATA  = 8'h11;
        kick();
        for (int k = 1; k <= 34; k++) begin
            step();
            TX_REQ   = 1'b0;
            TX_DATA  = (cyc == 19) ? 8'h80 : 8'h11;
            TX_VALID = (cyc < 20);
            ed = (cyc == 18) ? 8'hB8 : (cyc == 19) ? 8'h11 : (cyc == 20) ? 8'h80 : 8'h00;
            chk_all("underflow", ed, (cyc >= 8 && cyc <= 27), (cyc >= 28), (cyc <= 4 || cyc >= 28),
                    (cyc >= 18 && cyc <= 20), (cyc <= 32), (cyc == 21));
        end
        step();

        // PLL loss during HSZERO
        kick();
        for (int k = 1; k <= 17; k++) begin
            step();
            TX_REQ = 1'b0;
            if (cyc == 10) PLL_LOCK = 1'b0;
            if (cyc == 12) PLL_LOCK = 1'b1;
            chk_all("pll_loss", 8'h00, (cyc >= 8 && cyc <= 10), (cyc >= 11), (cyc <= 4 || cyc >= 11),
                    1'b0, (cyc <= 16), (cyc == 11));
        end

        // PLL gating in STOP
        PLL_LOCK = 1'b0;
        TX_REQ   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all("gate", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        TX_REQ   = 1'b0;
        PLL_LOCK = 1'b1;
        step();

        // Reset pulsed during PAYLOAD
        TX_VALID = 1'b1;
        TX_DATA  = 8'h5A;
        kick();
        for (int k = 1; k <= 21; k++) begin
            step();
            TX_REQ = 1'b0;
            if (cyc == 20) RST = 1'b1;
            ed = (cyc == 18) ? 8'hB8 : (cyc == 19 || cyc == 20) ? 8'h5A : 8'h00;
            chk_all("mid_reset", ed, (cyc >= 8 && cyc <= 20), (cyc >= 21), (cyc <= 4 || cyc >= 21),
                    (cyc >= 18 && cyc <= 20), (cyc <= 20), 1'b0);
        end
        RST      = 1'b0;
        TX_VALID = 1'b0;
        step();

        // Back-to-back: TX_REQ held, single byte 0x3C per burst
        TX_VALID = 1'b1;
        TX_DATA  = 8'h3C;
        TX_LAST  = 1'b1;
        kick();
        for (int k = 1; k <= 61; k++) begin
            step();
            if (cyc == 32) TX_REQ = 1'b0;
            if (cyc <= 36) begin
                ed = (cyc == 18) ? 8'hB8 : (cyc == 19) ? 8'h3C :
                     (cyc >= 20 && cyc <= 25) ? 8'hFF : 8'h00;
                chk_all("b2b", ed, (cyc >= 8 && cyc <= 25), (cyc >= 26 && cyc <= 30),
                        (cyc <= 4 || (cyc >= 26 && cyc <= 34)), (cyc == 18), 1'b1, 1'b0);
            end
            if (cyc == 49) chk("b2b.second_byte", HS_TX_DATA, 8'h3C);
            if (cyc == 60) chk("b2b.active_tail", {7'd0, TX_ACTIVE}, 8'h01);
            if (cyc == 61) chk("b2b.active_end", {7'd0, TX_ACTIVE}, 8'h00);
        end
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
